ikari_front2_linebuf: RTL and testbench

- Pixel-sink at the far end of the Front2 32x32 sprite generator's serial pixel stream.
- Captures the F2D pixel codes produced during line N into a double-buffered line RAM, then replays them on line N+1 indexed by the display X counter.
- Erases each location as it is read.
- Feeds the sprite pixel code into the colour mixer/priority stage.

---
 rtl/ikari_front2_linebuf_pkg.sv | 20 ++
 rtl/ikari_front2_linebuf_if.sv | 31 +++
 rtl/SRAM_dual_sync.sv | 31 +++
 rtl/ikari_lb_wrptr.sv | 31 +++
 rtl/ikari_front2_linebuf.sv | 138 +++++++++++++
 tb/tb_ikari_front2_linebuf.sv | 192 +++++++++++++++++++
 6 files changed

// File: rtl/ikari_front2_linebuf_pkg.sv
// Shared constants and types for the Front2 sprite line buffer.
package ikari_front2_lb_pkg;

  // Default geometry: 512 pixels per line bank, 7 stored bits per pixel.
  localparam int LB_XW = 9;
  localparam int LB_DW = 7;

  // Colour index that marks a transparent sprite pixel.
  localparam logic [2:0] LB_TRANSP = 3'b111;

  // Value held by an empty / erased location (transparent, all ones).
  localparam logic [LB_DW-1:0] LB_ERASED = 7'h7F;

  // Controller states: post-reset RAM clear, then normal line operation.
  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } lb_state_e;

endpackage

// File: rtl/ikari_front2_linebuf_if.sv
// Pixel-stream and display-side signal bundle for the sprite line buffer.
// The master side drives the Front2 stream and the display strobes;
// the slave side is the line buffer itself.
interface ikari_front2_linebuf_if
  import ikari_front2_lb_pkg::*;
#(
  parameter int XW = LB_XW
);

  logic [7:0]    F2D;
  logic          wr_cen;
  logic          x_ld;
  logic [XW-1:0] x_start;
  logic          line_swap;
  logic          rd_cen;
  logic [XW-1:0] rd_x;
  logic [7:0]    pix_out;
  logic          pix_opaque;
  logic          busy;

  modport master (
    output F2D, wr_cen, x_ld, x_start, line_swap, rd_cen, rd_x,
    input  pix_out, pix_opaque, busy
  );

  modport slave (
    input  F2D, wr_cen, x_ld, x_start, line_swap, rd_cen, rd_x,
    output pix_out, pix_opaque, busy
  );

endinterface

// File: rtl/SRAM_dual_sync.sv
// Generic true dual-port synchronous RAM with registered read data.
// Both ports read the old contents on a same-clock write; if both ports
// write the same address in one clock, port A wins.
module SRAM_dual_sync #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic [ADDR_WIDTH-1:0] ADDR_A,
  input  logic [ADDR_WIDTH-1:0] ADDR_B,
  input  logic [DATA_WIDTH-1:0] DATA_A,
  input  logic [DATA_WIDTH-1:0] DATA_B,
  input  logic                  WE_A,
  input  logic                  WE_B,
  output logic [DATA_WIDTH-1:0] Q_A,
  output logic [DATA_WIDTH-1:0] Q_B
);

  logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];

  // Write both ports (A last so it wins a collision) and register read data.
  // NOTE: the array has no reset branch so it maps onto block RAM; clearing
  // the contents is the controller's job.
  always_ff @(posedge clk) begin
    if (WE_B) r_mem[ADDR_B] <= DATA_B;
    if (WE_A) r_mem[ADDR_A] <= DATA_A;
    Q_A <= r_mem[ADDR_A];
    Q_B <= r_mem[ADDR_B];
  end

endmodule

// File: rtl/ikari_lb_wrptr.sv
// Write X pointer for the sprite line buffer: loaded at sprite start,
// stepped once per serial pixel, wrapping modulo 2**XW.
module ikari_lb_wrptr #(
  parameter int XW = 9
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_run,
  input  logic          i_ld,
  input  logic [XW-1:0] i_x_start,
  input  logic          i_step,
  output logic [XW-1:0] o_wptr
);

  logic [XW-1:0] r_wptr;

  // Load has priority over step; the current pixel always uses the old value.
  // NOTE: state registers use non-blocking assignment so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wptr <= '0;
    end else if (i_run) begin
      if (i_ld)        r_wptr <= i_x_start;
      else if (i_step) r_wptr <= r_wptr + 1'b1;
    end
  end

  assign o_wptr = r_wptr;

endmodule

// File: rtl/ikari_front2_linebuf.sv
// Double-buffered sprite line buffer at the end of the Front2 pixel stream.
// Line N is written into the write bank while line N-1 is replayed from the
// read bank by display X, each location being erased as it is read.
module ikari_front2_linebuf
  import ikari_front2_lb_pkg::*;
#(
  parameter int         XW     = LB_XW,
  parameter int         DW     = LB_DW,
  parameter logic [2:0] TRANSP = LB_TRANSP
) (
  input  logic                   clk,
  input  logic                   VIDEO_RSTn,
  ikari_front2_linebuf_if.slave  lb
);

  localparam logic [DW-1:0] ERASED = LB_ERASED;

  // Controller state
  lb_state_e     r_state;
  logic [XW-1:0] r_clr_cnt;
  logic          r_wbank;
  logic          r_busy;
  logic          r_erase_pend;
  logic [XW:0]   r_erase_addr;
  logic [7:0]    r_pix_out;
  logic          r_pix_opaque;

  // Datapath wires
  logic          w_run;
  logic          w_wr_opaque;
  logic          w_rd_go;
  logic [XW-1:0] w_wptr;
  logic [XW:0]   w_addr_a;
  logic [XW:0]   w_addr_b;
  logic [DW-1:0] w_din_a;
  logic [DW-1:0] w_din_b;
  logic          w_we_a;
  logic          w_we_b;
  logic [DW-1:0] w_q_a;
  logic [DW-1:0] w_q_b;
  logic          w_unused;

  assign w_run       = (r_state == RUN) && VIDEO_RSTn;
  assign w_wr_opaque = lb.wr_cen && (lb.F2D[2:0] != TRANSP);
  assign w_rd_go     = w_run && lb.rd_cen && !r_erase_pend;

  // Pixel bit 7 is architecturally zero and port A read data is not needed.
  assign w_unused = ^{w_q_a, lb.F2D[7]};

  ikari_lb_wrptr #(.XW(XW)) u_wrptr (
    .clk       (clk),
    .rst_n     (VIDEO_RSTn),
    .i_run     (w_run),
    .i_ld      (lb.x_ld),
    .i_x_start (lb.x_start),
    .i_step    (lb.wr_cen),
    .o_wptr    (w_wptr)
  );

  // Port steering: clearing uses both ports on opposite banks; in RUN port A
  // writes opaque pixels and port B alternates read / erase on the read bank.
  // NOTE: every output gets a default first so no path leaves a latch.
  always_comb begin
    w_addr_a = {1'b0, r_clr_cnt};
    w_din_a  = ERASED;
    w_we_a   = 1'b1;
    w_addr_b = {1'b1, r_clr_cnt};
    w_din_b  = ERASED;
    w_we_b   = 1'b1;
    if (w_run) begin
      w_addr_a = {r_wbank, w_wptr};
      w_din_a  = lb.F2D[DW-1:0];
      w_we_a   = w_wr_opaque;
      if (r_erase_pend) begin
        w_addr_b = r_erase_addr;
      end else begin
        w_addr_b = {~r_wbank, lb.rd_x};
        w_we_b   = 1'b0;
      end
    end
  end

  SRAM_dual_sync #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (XW + 1)
  ) u_ram (
    .clk    (clk),
    .ADDR_A (w_addr_a),
    .ADDR_B (w_addr_b),
    .DATA_A (w_din_a),
    .DATA_B (w_din_b),
    .WE_A   (w_we_a),
    .WE_B   (w_we_b),
    .Q_A    (w_q_a),
    .Q_B    (w_q_b)
  );

  // Clear/run FSM with bank toggle, erase tracking and registered pixel output.
  always_ff @(posedge clk) begin
    if (!VIDEO_RSTn) begin
      r_state      <= CLEAR;
      r_clr_cnt    <= '0;
      r_wbank      <= 1'b0;
      r_busy       <= 1'b1;
      r_erase_pend <= 1'b0;
      r_erase_addr <= '0;
      r_pix_out    <= 8'h07;
      r_pix_opaque <= 1'b0;
    end else begin
      case (r_state)
        CLEAR: begin
          r_clr_cnt <= r_clr_cnt + 1'b1;
          if (r_clr_cnt == {XW{1'b1}}) begin
            r_state <= RUN;
            r_busy  <= 1'b0;
          end
        end
        RUN: begin
          if (lb.line_swap) r_wbank <= ~r_wbank;
          // The erase address is frozen at read time, so a swap in between
          // cannot redirect the erase to the other bank.
          r_erase_pend <= w_rd_go;
          if (w_rd_go) r_erase_addr <= w_addr_b;
          if (r_erase_pend) begin
            r_pix_out    <= {{(8-DW){1'b0}}, w_q_b};
            r_pix_opaque <= (w_q_b[2:0] != TRANSP);
          end
        end
        default: r_state <= CLEAR;
      endcase
    end
  end

  assign lb.pix_out    = r_pix_out;
  assign lb.pix_opaque = r_pix_opaque;
  assign lb.busy       = r_busy;

endmodule

// File: tb/tb_ikari_front2_linebuf.sv
// Self-checking bench for the Front2 sprite line buffer. A two-bank array
// model applies the write / read-erase / swap rules directly and predicts
// every pixel read back from the display side.
module tb_ikari_front2_linebuf;
  import ikari_front2_lb_pkg::*;

  localparam int XW = 9;
  localparam int NX = 2**XW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ikari_front2_linebuf_if #(.XW(XW)) lb ();

  ikari_front2_linebuf #(.XW(XW)) dut (
    .clk        (clk),
    .VIDEO_RSTn (rst_n),
    .lb         (lb)
  );

  // Reference model: two line banks, write bank select, write pointer.
  logic [6:0]    m_bank [2][NX];
  logic          m_wb;
  logic [XW-1:0] m_wptr;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    lb.F2D = 8'h00; lb.wr_cen = 1'b0; lb.x_ld = 1'b0; lb.x_start = '0;
    lb.line_swap = 1'b0; lb.rd_cen = 1'b0; lb.rd_x = '0;
  endtask

  task automatic model_clear();
    for (int b = 0; b < 2; b++)
      for (int x = 0; x < NX; x++) m_bank[b][x] = 7'h7F;
    m_wb = 1'b0;
    m_wptr = '0;
  endtask

  // One clock of write-side activity; inputs change just after a falling edge.
  task automatic step(input bit wr, input logic [7:0] f2d, input bit ld,
                      input logic [XW-1:0] xs, input bit swap);
    lb.wr_cen = wr; lb.F2D = f2d; lb.x_ld = ld; lb.x_start = xs; lb.line_swap = swap;
    @(negedge clk);
    lb.wr_cen = 1'b0; lb.x_ld = 1'b0; lb.line_swap = 1'b0;
    if (wr) begin
      if (f2d[2:0] != 3'b111) m_bank[m_wb][m_wptr] = f2d[6:0];
      m_wptr = m_wptr + 1'b1;
    end
    if (ld) m_wptr = xs;
    if (swap) m_wb = ~m_wb;
  endtask

  task automatic sprite(input logic [XW-1:0] xs, input logic [7:0] first, input int len);
    step(1'b0, 8'h00, 1'b1, xs, 1'b0);
    for (int i = 0; i < len; i++) step(1'b1, first + 8'(i), 1'b0, '0, 1'b0);
  endtask

  task automatic swap_bank();
    step(1'b0, 8'h00, 1'b0, '0, 1'b1);
  endtask

  // Strobe one display read, wait for the registered result, compare.
  task automatic read_chk(input string tag, input logic [XW-1:0] x);
    logic [7:0] exp;
    lb.rd_cen = 1'b1; lb.rd_x = x;
    @(negedge clk);
    lb.rd_cen = 1'b0;
    @(negedge clk);
    @(negedge clk);
    exp = {1'b0, m_bank[~m_wb][x]};
    m_bank[~m_wb][x] = 7'h7F;
    check($sformatf("%s_pix_x%0h", tag, x), 32'(lb.pix_out), 32'(exp));
    check($sformatf("%s_opq_x%0h", tag, x), 32'(lb.pix_opaque), 32'(exp[2:0] != 3'b111));
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (lb.busy && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_ready"}, 32'(lb.busy), 32'd0);
  endtask

  initial begin
    int n;
    logic [7:0] px;
    idle_inputs();
    model_clear();

    // Reset values while VIDEO_RSTn is held low.
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(lb.busy), 32'd1);
    check("rst_pix", 32'(lb.pix_out), 32'h07);
    check("rst_opq", 32'(lb.pix_opaque), 32'd0);

    // Clear length: busy must fall on exactly the 512th clock after release.
    rst_n = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (lb.busy && n < 2000);
    check("clear_len", 32'(n), 32'd512);
    @(negedge clk);

    // Fresh buffer reads transparent everywhere, in both banks.
    for (int i = 0; i < 4; i++) read_chk("init", XW'($urandom_range(0, NX-1)));
    swap_bank();
    for (int i = 0; i < 4; i++) read_chk("init", XW'($urandom_range(0, NX-1)));

    // Basic sprite with a trailing transparent pixel, plus erase-on-read.
    sprite(9'h010, 8'h18, 8);
    swap_bank();
    for (int x = 'h10; x <= 'h17; x++) read_chk("basic", XW'(x));
    read_chk("erase", 9'h012);

    // Write pointer wrap at the end of the line.
    sprite(9'h1FE, 8'h21, 4);
    swap_bank();
    read_chk("wrap", 9'h1FE);
    read_chk("wrap", 9'h1FF);
    read_chk("wrap", 9'h000);
    read_chk("wrap", 9'h001);

    // Overlap: last opaque writer wins, transparent leaves the earlier pixel.
    sprite(9'h040, 8'h30, 1);
    sprite(9'h040, 8'h45, 1);
    sprite(9'h041, 8'h30, 1);
    sprite(9'h041, 8'h47, 1);
    swap_bank();
    read_chk("ovl", 9'h040);
    read_chk("ovl", 9'h041);

    // Write in the same clock as the swap lands in the pre-swap bank;
    // load with a simultaneous write uses the old pointer.
    sprite(9'h080, 8'h50, 2);
    step(1'b1, 8'h62, 1'b1, 9'h090, 1'b0);
    step(1'b1, 8'h63, 1'b0, '0, 1'b0);
    step(1'b1, 8'h55, 1'b0, '0, 1'b1);
    for (int x = 'h80; x <= 'h83; x++) read_chk("simul", XW'(x));
    read_chk("simul", 9'h090);
    read_chk("simul", 9'h091);

    // Randomised lines: several sprites per line, random reads afterwards.
    for (int line = 0; line < 6; line++) begin
      int ns;
      ns = int'($urandom_range(1, 4));
      for (int s = 0; s < ns; s++) begin
        step(1'b0, 8'h00, 1'b1, XW'($urandom_range(0, NX-1)), 1'b0);
        for (int p = 0; p < int'($urandom_range(8, 40)); p++) begin
          px = {1'b0, 7'($urandom)};
          if ($urandom_range(0, 3) == 0) px[2:0] = 3'b111;
          step(1'b1, px, 1'b0, '0, 1'b0);
        end
      end
      swap_bank();
      for (int r = 0; r < 20; r++) read_chk("rnd", XW'($urandom_range(0, NX-1)));
    end

    // Reset in the middle of a line.
    sprite(9'h100, 8'h70, 6);
    lb.rd_cen = 1'b1; lb.rd_x = 9'h020;
    rst_n = 1'b0;
    @(negedge clk);
    lb.rd_cen = 1'b0;
    @(negedge clk);
    check("mid_rst_busy", 32'(lb.busy), 32'd1);
    rst_n = 1'b1;
    model_clear();
    wait_ready("mid_rst");
    swap_bank();
    for (int x = 'h100; x < 'h106; x++) read_chk("post_rst", XW'(x));
    swap_bank();
    for (int i = 0; i < 6; i++) read_chk("post_rst", XW'($urandom_range(0, NX-1)));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
